// File: rtl/kmeans_apb_sequencer.sv
// kmeans_apb_sequencer: APB master running one full k-means job on
// k_means_top (centroid load, point load, go, irq wait, read-back).
module kmeans_apb_sequencer #(
  parameter int addrWidth     = 9,
  parameter int dataWidth     = 91,
  parameter int centroid_num  = 8,
  parameter int log2_cent_num = 3,
  parameter int irq_timeout   = 65535
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [addrWidth-1:0]     first_addr,
  input  logic [addrWidth-1:0]     last_addr,
  output logic                     cent_rd_en,
  output logic [log2_cent_num-1:0] cent_rd_idx,
  input  logic [dataWidth-1:0]     cent_rd_data,
  output logic                     pt_rd_en,
  output logic [addrWidth-1:0]     pt_rd_addr,
  input  logic [dataWidth-1:0]     pt_rd_data,
  output logic [addrWidth-1:0]     paddr,
  output logic                     pwrite,
  output logic                     psel,
  output logic                     penable,
  output logic [dataWidth-1:0]     pwdata,
  input  logic [dataWidth-1:0]     prdata,
  input  logic                     pready,
  input  logic                     interupt,
  output logic                     busy,
  output logic                     res_valid,
  output logic [log2_cent_num-1:0] res_idx,
  output logic [dataWidth-1:0]     res_data,
  output logic                     done,
  output logic [1:0]               err_code
);

  localparam int TW = $clog2(irq_timeout + 1);

  localparam logic [addrWidth-1:0] A_GO    = addrWidth'(1);
  localparam logic [addrWidth-1:0] A_CENT  = addrWidth'(2);
  localparam logic [addrWidth-1:0] A_RADDR = addrWidth'(10);
  localparam logic [addrWidth-1:0] A_RDATA = addrWidth'(11);
  localparam logic [addrWidth-1:0] A_FIRST = addrWidth'(12);
  localparam logic [addrWidth-1:0] A_LAST  = addrWidth'(13);

  localparam logic [log2_cent_num-1:0] CI_ONE  = log2_cent_num'(1);
  localparam logic [log2_cent_num-1:0] CI_LAST =
    log2_cent_num'(centroid_num - 1);
  localparam logic [addrWidth:0] PT_ONE = (addrWidth + 1)'(1);
  localparam logic [TW-1:0]      TMO    = TW'(irq_timeout);
  localparam logic [TW-1:0]      T_ONE  = TW'(1);

  typedef enum logic [2:0] {
    IDLE, CHECK, PREP, CAPT, SETUP, ACCESS, WAIT_IRQ, DONE
  } state_e;

  typedef enum logic [2:0] {
    T_CENT, T_FIRST, T_LAST, T_RADDR, T_RDATA, T_GO, T_READ, T_FIN
  } xfer_e;

  state_e                   state_q, state_d;
  xfer_e                    xfer_q, xfer_d;
  logic [log2_cent_num-1:0] cidx_q, cidx_d;
  logic [addrWidth:0]       ptr_q, ptr_d;
  logic [TW-1:0]            cnt_q, cnt_d;
  logic [1:0]               err_d;
  logic [addrWidth-1:0]     first_q, last_q;
  logic                     irq_q;
  logic                     irq_rise;

  logic [addrWidth-1:0]     cap_addr;
  logic [dataWidth-1:0]     cap_data;
  logic                     cap_wr;

  assign irq_rise = interupt & ~irq_q;

  always_comb begin
    state_d = state_q;
    xfer_d  = xfer_q;
    cidx_d  = cidx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_code;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CHECK;
          err_d   = 2'd0;
        end
      end
      CHECK: begin
        if (last_q < first_q) begin
          state_d = DONE;
          err_d   = 2'd1;
        end else begin
          state_d = PREP;
          xfer_d  = T_CENT;
          cidx_d  = '0;
        end
      end
      PREP:  state_d = (xfer_q == T_FIN) ? DONE : CAPT;
      CAPT:  state_d = SETUP;
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          state_d = PREP;
          unique case (xfer_q)
            T_CENT: begin
              if (cidx_q == CI_LAST) xfer_d = T_FIRST;
              else cidx_d = cidx_q + CI_ONE;
            end
            T_FIRST: xfer_d = T_LAST;
            T_LAST: begin
              xfer_d = T_RADDR;
              ptr_d  = {1'b0, first_q};
            end
            T_RADDR: xfer_d = T_RDATA;
            // compare before increment so last=511 never wraps
            T_RDATA: begin
              if (ptr_q[addrWidth-1:0] == last_q) begin
                xfer_d = T_GO;
              end else begin
                xfer_d = T_RADDR;
                ptr_d  = ptr_q + PT_ONE;
              end
            end
            T_GO: begin
              state_d = WAIT_IRQ;
              cnt_d   = '0;
            end
            T_READ: begin
              if (cidx_q == CI_LAST) xfer_d = T_FIN;
              else cidx_d = cidx_q + CI_ONE;
            end
            T_FIN: state_d = DONE;
          endcase
        end
      end
      WAIT_IRQ: begin
        cnt_d = cnt_q + T_ONE;
        if (irq_rise) begin
          state_d = PREP;
          xfer_d  = T_READ;
          cidx_d  = '0;
        end else if (cnt_q == TMO) begin
          state_d = DONE;
          err_d   = 2'd2;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_comb begin
    cap_wr   = 1'b1;
    cap_addr = A_GO;
    cap_data = '0;
    unique case (xfer_q)
      T_CENT: begin
        cap_addr = A_CENT + addrWidth'(cidx_q);
        cap_data = cent_rd_data;
      end
      T_FIRST: begin
        cap_addr = A_FIRST;
        cap_data = dataWidth'(first_q);
      end
      T_LAST: begin
        cap_addr = A_LAST;
        cap_data = dataWidth'(last_q);
      end
      T_RADDR: begin
        cap_addr = A_RADDR;
        cap_data = dataWidth'(ptr_q);
      end
      T_RDATA: begin
        cap_addr = A_RDATA;
        cap_data = pt_rd_data;
      end
      T_GO: begin
        cap_addr = A_GO;
        cap_data = dataWidth'(1);
      end
      T_READ: begin
        cap_wr   = 1'b0;
        cap_addr = A_CENT + addrWidth'(cidx_q);
      end
      T_FIN: cap_wr = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    irq_q <= interupt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      xfer_q      <= T_CENT;
      cidx_q      <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      first_q     <= '0;
      last_q      <= '0;
      cent_rd_en  <= 1'b0;
      cent_rd_idx <= '0;
      pt_rd_en    <= 1'b0;
      pt_rd_addr  <= '0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwdata      <= '0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      res_idx     <= '0;
      res_data    <= '0;
      done        <= 1'b0;
      err_code    <= 2'd0;
    end else begin
      state_q  <= state_d;
      xfer_q   <= xfer_d;
      cidx_q   <= cidx_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      err_code <= err_d;
      if (state_q == IDLE && start) begin
        first_q <= first_addr;
        last_q  <= last_addr;
      end
      cent_rd_en  <= (state_d == PREP) && (xfer_d == T_CENT);
      cent_rd_idx <= cidx_d;
      pt_rd_en    <= (state_d == PREP) && (xfer_d == T_RDATA);
      pt_rd_addr  <= ptr_d[addrWidth-1:0];
      psel        <= (state_d == SETUP) || (state_d == ACCESS);
      penable     <= (state_d == ACCESS);
      busy        <= (state_d != IDLE) && (state_d != DONE);
      done        <= (state_d == DONE);
      if (state_q == CAPT) begin
        paddr  <= cap_addr;
        pwdata <= cap_data;
        pwrite <= cap_wr;
      end
      res_valid <= (state_q == ACCESS) && pready && (xfer_q == T_READ);
      if ((state_q == ACCESS) && pready && (xfer_q == T_READ)) begin
        res_idx  <= cidx_q;
        res_data <= prdata;
      end
    end
  end

endmodule

// File: tb/tb_kmeans_apb_sequencer.sv
// tb_kmeans_apb_sequencer: directed bench for kmeans_apb_sequencer
// with source buffers, APB slave model and transfer log.
module tb_kmeans_apb_sequencer;

  localparam int AW = 9;
  localparam int DW = 91;
  localparam int CW = 3;

  typedef logic [100:0] xfer_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] last_addr;
  logic          cent_rd_en;
  logic [CW-1:0] cent_rd_idx;
  logic [DW-1:0] cent_rd_data;
  logic          pt_rd_en;
  logic [AW-1:0] pt_rd_addr;
  logic [DW-1:0] pt_rd_data;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          interupt;
  logic          busy;
  logic          res_valid;
  logic [CW-1:0] res_idx;
  logic [DW-1:0] res_data;
  logic          done;
  logic [1:0]    err_code;

  int checks = 0;
  int failures = 0;

  kmeans_apb_sequencer #(
    .addrWidth(AW), .dataWidth(DW), .centroid_num(8),
    .log2_cent_num(CW), .irq_timeout(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .first_addr(first_addr), .last_addr(last_addr),
    .cent_rd_en(cent_rd_en), .cent_rd_idx(cent_rd_idx),
    .cent_rd_data(cent_rd_data),
    .pt_rd_en(pt_rd_en), .pt_rd_addr(pt_rd_addr),
    .pt_rd_data(pt_rd_data),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .interupt(interupt), .busy(busy), .res_valid(res_valid),
    .res_idx(res_idx), .res_data(res_data), .done(done),
    .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] cent_word(int i);
    return {8'hC5, 80'd0, 3'(i)};
  endfunction

  function automatic logic [DW-1:0] pt_word(int a);
    return {8'hA7, 74'd0, 9'(a)};
  endfunction

  function automatic logic [DW-1:0] rd_word(int a);
    return {8'h3D, 74'd0, 9'(a)};
  endfunction

  initial begin
    cent_rd_data = '0;
    pt_rd_data = '0;
  end

  always @(posedge clk) begin
    if (cent_rd_en) cent_rd_data <= cent_word(int'(cent_rd_idx));
    if (pt_rd_en) pt_rd_data <= pt_word(int'(pt_rd_addr));
  end

  assign prdata = (psel && !pwrite) ? rd_word(int'(paddr)) : '0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  xfer_t         xlog[$];
  int            alen[$];
  bit            astab[$];
  logic [CW-1:0] ridx[$];
  logic [DW-1:0] rdat[$];
  int cyc = 0;
  int go_n = 0, go_cyc = 0, done_n = 0, done_cyc = 0;
  int res_cyc = 0, prep0_cyc = 0, psel_n = 0;
  logic [1:0]    done_err = 2'd0;
  logic [AW-1:0] a0 = '0;
  logic [DW-1:0] d0 = '0;
  logic          w0 = 1'b0;
  int            acnt = 0;
  bit            stab = 1'b0, in_acc = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (psel) psel_n++;
    if (cent_rd_en && cent_rd_idx == 0) prep0_cyc = cyc;
    if (res_valid) begin
      ridx.push_back(res_idx);
      rdat.push_back(res_data);
      res_cyc = cyc;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
      done_err = err_code;
    end
    if (psel && penable) begin
      if (!in_acc) begin
        in_acc = 1'b1; acnt = 1; stab = 1'b1;
        a0 = paddr; d0 = pwdata; w0 = pwrite;
      end else begin
        acnt++;
        if (paddr !== a0 || pwdata !== d0 || pwrite !== w0) stab = 1'b0;
      end
      if (pready) begin
        xlog.push_back({pwrite, paddr, pwdata});
        alen.push_back(acnt);
        astab.push_back(stab);
        in_acc = 1'b0;
        if (pwrite && paddr == 1) begin
          go_n++;
          go_cyc = cyc;
        end
      end
    end else begin
      in_acc = 1'b0;
    end
  end

  int stall_req = 0;
  int stall_seen = 0;
  initial begin
    pready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_req != stall_seen && psel && !penable && paddr == 11) begin
        stall_seen = stall_req;
        pready = 1'b0;
        repeat (4) @(posedge clk);
        #1 pready = 1'b1;
      end
    end
  end

  task automatic cmp_job(input string tag, input int f, input int l,
                         input int xb, input int rb, input bit reads);
    xfer_t e[$];
    for (int i = 0; i < 8; i++) e.push_back({1'b1, 9'(2 + i), cent_word(i)});
    e.push_back({1'b1, 9'd12, DW'(f)});
    e.push_back({1'b1, 9'd13, DW'(l)});
    for (int a = f; a <= l; a++) begin
      e.push_back({1'b1, 9'd10, DW'(a)});
      e.push_back({1'b1, 9'd11, pt_word(a)});
    end
    e.push_back({1'b1, 9'd1, DW'(1)});
    if (reads)
      for (int i = 0; i < 8; i++) e.push_back({1'b0, 9'(2 + i), DW'(0)});
    chk({tag, "_nxfer"}, 128'(xlog.size() - xb), 128'(e.size()));
    for (int i = 0; i < e.size() && xb + i < xlog.size(); i++)
      chk($sformatf("%s_x%0d", tag, i), 128'(xlog[xb + i]), 128'(e[i]));
    chk({tag, "_nres"}, 128'(ridx.size() - rb), reads ? 128'd8 : 128'd0);
    if (reads)
      for (int i = 0; i < 8 && rb + i < ridx.size(); i++)
        chk($sformatf("%s_r%0d", tag, i), 128'({ridx[rb + i], rdat[rb + i]}),
            128'({3'(i), rd_word(2 + i)}));
  endtask

  task automatic do_job(input int f, input int l, input int irq_dly,
                        input bit pulse, input int budget);
    int g0;
    int dn0;
    g0 = go_n;
    dn0 = done_n;
    @(posedge clk);
    #1 start = 1'b1; first_addr = AW'(f); last_addr = AW'(l);
    @(posedge clk);
    #1 start = 1'b0;
    if (pulse) begin
      repeat (5) @(posedge clk);
      #1 start = 1'b1; first_addr = 9'd7; last_addr = 9'd3;
      @(posedge clk);
      #1 start = 1'b0;
    end
    if (irq_dly >= 0) begin
      for (int i = 0; i < budget && go_n == g0; i++) @(negedge clk);
      repeat (irq_dly) @(posedge clk);
      #1 interupt = 1'b1;
    end
    for (int i = 0; i < budget && done_n == dn0; i++) @(negedge clk);
    chk("done_seen", 128'(done_n - dn0), 128'd1);
    if (irq_dly >= 0) begin
      @(posedge clk);
      #1 interupt = 1'b0;
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int xb, rb, p0, dl;
    rst_n = 1'b0; start = 1'b0; interupt = 1'b0;
    first_addr = '0; last_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_psel", 128'(psel), 128'd0);
    chk("rst_penable", 128'(penable), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_resv", 128'(res_valid), 128'd0);
    chk("rst_err", 128'(err_code), 128'd0);
    chk("rst_rden", 128'({cent_rd_en, pt_rd_en}), 128'd0);
    chk("rst_apb", 128'({paddr, pwdata, pwrite}), 128'd0);
    rst_n = 1'b1;

    // job 1: 1..10, ignored start mid-run
    xb = xlog.size(); rb = ridx.size();
    do_job(1, 10, 20, 1'b1, 3000);
    cmp_job("t1", 1, 10, xb, rb, 1'b1);
    chk("t1_err", 128'(done_err), 128'd0);
    chk("t1_wphase", 128'(go_cyc - prep0_cyc + 1), 128'd124);
    chk("t1_done_after_res", 128'(done_cyc - res_cyc), 128'd1);
    chk("t1_busy_end", 128'(busy), 128'd0);

    // job 2: stall on first RAM_data write
    xb = xlog.size(); rb = ridx.size();
    stall_req++;
    do_job(1, 10, 20, 1'b0, 3000);
    cmp_job("t2", 1, 10, xb, rb, 1'b1);
    chk("t2_err", 128'(done_err), 128'd0);
    if (alen.size() > xb + 11) begin
      chk("t2_alen_ram", 128'(alen[xb + 11]), 128'd4);
      chk("t2_stable", 128'(astab[xb + 11]), 128'd1);
      chk("t2_alen_prev", 128'(alen[xb + 10]), 128'd1);
    end else begin
      chk("t2_xfer_missing", 128'(alen.size()), 128'(xb + 12));
    end

    // job 3: bad range
    p0 = psel_n;
    @(posedge clk);
    #1 start = 1'b1; first_addr = 9'd5; last_addr = 9'd4;
    @(posedge clk);
    #1 start = 1'b0;
    chk("t3_busy1", 128'({busy, done}), 128'b10);
    @(posedge clk);
    #1;
    chk("t3_done", 128'({busy, done}), 128'b01);
    chk("t3_err", 128'(err_code), 128'd1);
    @(posedge clk);
    #1;
    chk("t3_after", 128'({busy, done}), 128'b00);
    chk("t3_err_hold", 128'(err_code), 128'd1);
    repeat (5) @(posedge clk);
    chk("t3_nopsel", 128'(psel_n - p0), 128'd0);

    // job 4: single point at top address
    xb = xlog.size(); rb = ridx.size();
    do_job(511, 511, 3, 1'b0, 2000);
    cmp_job("t4", 511, 511, xb, rb, 1'b1);
    chk("t4_err", 128'(done_err), 128'd0);

    // job 5: irq level held high, timeout
    interupt = 1'b1;
    repeat (3) @(posedge clk);
    xb = xlog.size(); rb = ridx.size();
    do_job(0, 0, -1, 1'b0, 1000);
    cmp_job("t5", 0, 0, xb, rb, 1'b0);
    chk("t5_err", 128'(done_err), 128'd2);
    dl = done_cyc - go_cyc;
    chk("t5_tmo_window", 128'(dl >= 100 && dl <= 103), 128'd1);
    #1 interupt = 1'b0;
    repeat (2) @(posedge clk);

    // job 6: reset during cent_3 ACCESS, then fresh job
    @(posedge clk);
    #1 start = 1'b1; first_addr = 9'd1; last_addr = 9'd10;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1; first_addr = 9'd7; last_addr = 9'd3;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (psel && penable && paddr == 4) break;
    end
    chk("t6_in_cent3", 128'({psel, penable, paddr}), 128'({2'b11, 9'd4}));
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("t6_rst_apb", 128'({psel, penable, busy}), 128'd0);
    chk("t6_rst_done", 128'({done, res_valid}), 128'd0);
    p0 = psel_n;
    repeat (10) @(posedge clk);
    chk("t6_quiet", 128'(psel_n - p0), 128'd0);
    xb = xlog.size(); rb = ridx.size();
    do_job(2, 3, 5, 1'b0, 2000);
    cmp_job("t6", 2, 3, xb, rb, 1'b1);
    chk("t6_err", 128'(done_err), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
